// File: rtl/store_write_buffer.sv
// Registered store path: decodes SB/SH/SW, checks alignment and region access,
// and queues byte-enabled, lane-replicated writes in a FIFO toward memory.
module store_write_buffer #(
  parameter int                       NUM_REGIONS = 3,
  parameter int                       DEPTH       = 4,
  parameter logic [4*NUM_REGIONS-1:0] REGION_BASE = {4'b1100, 4'b0010, 4'b0001},
  parameter logic [4*NUM_REGIONS-1:0] REGION_MASK = {4'b1111, 4'b1110, 4'b1101},
  parameter logic [NUM_REGIONS-1:0]   PROT_MASK   = 3'b010,
  localparam int                      CW          = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [5:0]             st_opcode,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [31:0]            st_pc,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [NUM_REGIONS-1:0] mem_region,
  output logic [3:0]             mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_data,
  output logic [CW-1:0]          buf_count,
  output logic                   buf_empty,
  output logic                   misalign_err,
  output logic                   unmapped_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  logic is_sb, is_sh, is_sw, accept, misaligned, push, pop;
  logic [NUM_REGIONS-1:0] region_hit;
  logic [3:0]  we_new;
  logic [31:0] data_new;

  logic [CW-1:0] count_reg, count_after_pop, count_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;

  logic [NUM_REGIONS-1:0] region_mem [DEPTH];
  logic [3:0]             we_mem     [DEPTH];
  logic [29:0]            addr_mem   [DEPTH];
  logic [31:0]            data_mem   [DEPTH];

  logic                   mem_valid_reg, mem_valid_next;
  logic [NUM_REGIONS-1:0] mem_region_reg, mem_region_next;
  logic [3:0]             mem_we_reg, mem_we_next;
  logic [29:0]            mem_addr_reg, mem_addr_next;
  logic [31:0]            mem_data_reg, mem_data_next;
  logic                   misalign_err_reg, unmapped_err_reg;

  logic unused_pc;
  assign unused_pc = ^{st_pc[31], st_pc[29:0]};

  assign is_sb = (st_opcode == OP_SB);
  assign is_sh = (st_opcode == OP_SH);
  assign is_sw = (st_opcode == OP_SW);

  assign st_ready   = (count_reg < DEPTH_C);
  assign accept     = st_valid && st_ready && (is_sb || is_sh || is_sw);
  assign misaligned = (is_sh && st_addr[0]) || (is_sw && (st_addr[1:0] != 2'b00));

  // Protected regions only count as a hit for privileged code.
  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    assign region_hit[gi] =
      ((st_addr[31:28] & REGION_MASK[4*gi +: 4]) ==
       (REGION_BASE[4*gi +: 4] & REGION_MASK[4*gi +: 4])) &&
      (!PROT_MASK[gi] || st_pc[30]);
  end

  assign push = accept && !misaligned && (region_hit != '0);
  assign pop  = mem_valid_reg && mem_ready;

  // Byte lane 0 (bit 3) is the lowest address: big-endian enables.
  always_comb begin
    we_new   = 4'b0000;
    data_new = st_data;
    if (is_sb) begin
      we_new   = 4'b1000 >> st_addr[1:0];
      data_new = {4{st_data[7:0]}};
    end else if (is_sh) begin
      we_new   = st_addr[1] ? 4'b0011 : 4'b1100;
      data_new = {2{st_data[15:0]}};
    end else if (is_sw) begin
      we_new   = 4'b1111;
    end
  end

  assign count_after_pop = count_reg - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);
  assign rd_ptr_next     = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

  // Next head: bypass a store landing in an otherwise empty FIFO.
  always_comb begin
    mem_valid_next  = 1'b0;
    mem_region_next = '0;
    mem_we_next     = 4'b0000;
    mem_addr_next   = '0;
    mem_data_next   = '0;
    if (count_next != '0) begin
      mem_valid_next = 1'b1;
      if (push && (count_after_pop == '0)) begin
        mem_region_next = region_hit;
        mem_we_next     = we_new;
        mem_addr_next   = st_addr[31:2];
        mem_data_next   = data_new;
      end else begin
        mem_region_next = region_mem[rd_ptr_next];
        mem_we_next     = we_mem[rd_ptr_next];
        mem_addr_next   = addr_mem[rd_ptr_next];
        mem_data_next   = data_mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      region_mem[wr_ptr_reg] <= region_hit;
      we_mem[wr_ptr_reg]     <= we_new;
      addr_mem[wr_ptr_reg]   <= st_addr[31:2];
      data_mem[wr_ptr_reg]   <= data_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg        <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      mem_valid_reg    <= 1'b0;
      mem_region_reg   <= '0;
      mem_we_reg       <= 4'b0000;
      mem_addr_reg     <= '0;
      mem_data_reg     <= '0;
      misalign_err_reg <= 1'b0;
      unmapped_err_reg <= 1'b0;
    end else begin
      count_reg        <= count_next;
      wr_ptr_reg       <= push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
      rd_ptr_reg       <= rd_ptr_next;
      mem_valid_reg    <= mem_valid_next;
      mem_region_reg   <= mem_region_next;
      mem_we_reg       <= mem_we_next;
      mem_addr_reg     <= mem_addr_next;
      mem_data_reg     <= mem_data_next;
      misalign_err_reg <= accept && misaligned;
      unmapped_err_reg <= accept && !misaligned && (region_hit == '0);
    end
  end

  assign mem_valid    = mem_valid_reg;
  assign mem_region   = mem_region_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = {mem_addr_reg, 2'b00};
  assign mem_data     = mem_data_reg;
  assign buf_count    = count_reg;
  assign buf_empty    = (count_reg == '0);
  assign misalign_err = misalign_err_reg;
  assign unmapped_err = unmapped_err_reg;

endmodule
